instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Producer side of the IF->ID instruction handoff.
- Owns the PC, issues word reads to instruction memory and buffers returned instructions in a small FIFO.
- Presents {Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} plus a valid flag to the downstream pipeline register, which pops the FIFO whenever it is not stalled.
- Handles front-end redirects (branch/mispredict) by flushing the buffer and discarding the stale in-flight response.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- QDEPTH, 2, output FIFO entries (power of 2, >=2).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- STALL  input  1  downstream freeze; no pop while high.
- REDIRECT  input  1  load REDIRECT_PC, flush buffer.
- REDIRECT_PC  input  32  new fetch address; word aligned.
- IMEM_REQ  output  1  read request valid.
- IMEM_ADDR  output  32  read address.
- IMEM_ACK  input  1  request accepted this cycle.
- IMEM_RVALID  input  1  read data valid.
- IMEM_RDATA  input  32  instruction word.
- Instr_VALID  output  1  FIFO head valid.
- Instr1_OUT  output  32  head instruction.
- Instr_PC_OUT  output  32  head PC.
- Instr_PC_Plus4  output  32  head PC+4.

Behaviour:
- Reset (async, RESET=0):
  - PC=RESET_PC.
  - FIFO empty, count=0.
  - State IDLE, drop flag=0.
  - IMEM_REQ=0, IMEM_ADDR=RESET_PC.
  - Instr_VALID=0; Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4 all 0.
  - Reset mid-transaction abandons any in-flight read; a response arriving after reset release while in IDLE is ignored.
- FSM: IDLE, REQ, WAIT. At most one read outstanding.
  - IDLE -> REQ when count < QDEPTH and no REDIRECT this cycle.
  - REQ: IMEM_REQ=1, IMEM_ADDR=PC (held stable until ACK). IMEM_ACK -> WAIT, PC <= PC+4 (mod 2^32, 32'hFFFFFFFC wraps to 0).
  - WAIT: IMEM_RVALID pushes {IMEM_RDATA, addr, addr+4}, where addr is the acknowledged address. Next state is REQ if space remains after this cycle's push/pop, else IDLE.
  - ACK and RVALID in the same cycle (zero-latency memory) are legal: treat as REQ->WAIT->push in one cycle.
- Output and pop:
  - Outputs come from registered FIFO head storage; no combinational path from IMEM_* to the outputs.
  - Pop on the rising edge when Instr_VALID=1 and STALL=0.
  - Push and pop in the same cycle is allowed when full; count stays unchanged.
  - When empty, Instr_VALID=0 and the data outputs hold their last values.
- REDIRECT (priority over everything else that cycle):
  - FIFO flushed, so Instr_VALID=0 next cycle. A same-cycle pop is irrelevant.
  - PC <= REDIRECT_PC.
  - REQ not yet ACKed: withdraw. Next cycle IMEM_REQ=1 with IMEM_ADDR=REDIRECT_PC. An ACK in the redirect cycle itself is treated as accepted-stale: set drop flag, go to WAIT.
  - WAIT: set drop flag, stay in WAIT. The next RVALID is discarded and clears the flag, then go to REQ at the new PC.
  - RVALID in the redirect cycle is discarded.
  - Back-to-back redirects: the last one wins; the drop flag stays set until exactly one response is consumed.
- Flow control: a request is issued only if count + (state==WAIT) < QDEPTH. The FIFO therefore never overflows and RVALID is never back-pressured.
- STALL has no effect on fetching until the FIFO fills.

Optional Feature:
- FETCH_TRACE_EN defined:
  - Each push prints $display("FETCH:Instr@%x=%x;Next@%x", pc, instr, pc+4).
  - Each discarded response prints "FETCH drop@%x".
  - Each redirect prints "FETCH redirect->%x".
- Undefined: no display statements. Logic is identical either way.

Test Plan:
- Reset then release with a 1-cycle-latency memory returning addr^32'h1234, STALL=0 -> IMEM_ADDR sequence BFC00000, BFC00004, ...; Instr_PC_OUT follows the same sequence, Instr_PC_Plus4 = PC+4, Instr1_OUT = PC^1234.
- Hold STALL=1 for 10 cycles -> exactly QDEPTH(2) pushes, IMEM_REQ=0 thereafter, head stays BFC00000. Release STALL -> entries drain in order, no loss or duplication.
- REDIRECT to 00400000 while in WAIT for BFC00008 -> the BFC00008 response is dropped, FIFO empties, next IMEM_ADDR=00400000, next valid Instr_PC_OUT=00400000.
- REDIRECT during REQ with ACK=0, then two redirects on consecutive cycles (00001000, then 00002000) -> first delivered PC is 00002000, and no response is delivered for any stale address.
- Zero-latency memory (ACK and RVALID in the same cycle) with PC=FFFFFFF8 -> delivers FFFFFFF8 then FFFFFFFC, then wraps to 00000000 with Instr_PC_Plus4=00000004.
- Assert RESET low while in WAIT, then pulse RVALID after release -> all outputs 0, Instr_VALID=0, the stray response is ignored, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one outstanding word read at a time and
// buffers returned instructions in a small FIFO. Define FETCH_TRACE_EN for fetch trace output.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        Instr_VALID,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4
);
    localparam int unsigned AddrW    = $clog2(QDEPTH);
    localparam logic [AddrW:0] DepthCnt = (AddrW+1)'(QDEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d, addr_q, addr_d;
    logic               drop_q, drop_d;
    logic [31:0]        instr_mem_q [QDEPTH];
    logic [31:0]        pc_mem_q [QDEPTH];
    logic [AddrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AddrW:0]     count_q, count_nxt;
    logic [31:0]        head_instr_q, head_instr_d, head_pc_q, head_pc_d, head_plus4_q;
    logic               push, pop, discard;
    logic [31:0]        push_pc;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        drop_d    = drop_q;
        push      = 1'b0;
        discard   = 1'b0;
        push_pc   = addr_q;
        pop       = (count_q != '0) && !STALL && !REDIRECT;
        unique case (state_q)
            StIdle: begin
                if (!REDIRECT && (count_q < DepthCnt)) state_d = StReq;
            end
            StReq: begin
                if (IMEM_ACK) begin
                    addr_d  = pc_q;
                    pc_d    = pc_q + 32'd4;
                    push_pc = pc_q;
                    if (REDIRECT && IMEM_RVALID) begin
                        discard = 1'b1;
                    end else if (REDIRECT) begin
                        // Accepted but stale: its response must be swallowed later.
                        drop_d  = 1'b1;
                        state_d = StWait;
                    end else if (IMEM_RVALID) begin
                        push = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (IMEM_RVALID) begin
                    if (REDIRECT || drop_q) begin
                        discard = 1'b1;
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        push = 1'b1;
                    end
                end else if (REDIRECT) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        count_nxt = count_q + (AddrW+1)'(push) - (AddrW+1)'(pop);
        if (push) state_d = (count_nxt < DepthCnt) ? StReq : StIdle;
        if (REDIRECT) pc_d = REDIRECT_PC;
    end

    always_comb begin
        IMEM_REQ  = (state_q == StReq);
        IMEM_ADDR = pc_q;
    end

    // Next head: the pushed word when the buffer drains to it, else the stored entry.
    always_comb begin
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        if (!REDIRECT && (count_nxt != '0)) begin
            if (count_q == (AddrW+1)'(pop)) begin
                head_instr_d = IMEM_RDATA;
                head_pc_d    = push_pc;
            end else begin
                head_instr_d = instr_mem_q[rd_ptr_q + AddrW'(pop)];
                head_pc_d    = pc_mem_q[rd_ptr_q + AddrW'(pop)];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_plus4_q <= '0;
        end else begin
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            head_plus4_q <= head_pc_d + 32'd4;
            if (REDIRECT) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_q + AddrW'(pop);
                wr_ptr_q <= wr_ptr_q + AddrW'(push);
                count_q  <= count_nxt;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= IMEM_RDATA;
            pc_mem_q[wr_ptr_q]    <= push_pc;
        end
    end

    assign Instr_VALID    = (count_q != '0);
    assign Instr1_OUT     = head_instr_q;
    assign Instr_PC_OUT   = head_pc_q;
    assign Instr_PC_Plus4 = head_plus4_q;

`ifdef FETCH_TRACE_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (push) $display("FETCH:Instr@%x=%x;Next@%x", push_pc, IMEM_RDATA, push_pc + 32'd4);
            if (discard) $display("FETCH drop@%x", push_pc);
            if (REDIRECT) $display("FETCH redirect->%x", REDIRECT_PC);
        end
    end
`endif

endmodule
